trivium_core_wide: RTL and testbench
====================================

# trivium_core_wide

Parametrised Trivium keystream core producing W keystream bits per clock by unrolling the round function W times across the full 288-bit state. It replaces the three bit-serial shift-register slices with one self-contained core that owns key/IV loading, the 1152-round warm-up, and a valid/ready keystream output. It sits between the key/IV configuration registers and the cipher datapath.

## Interface
Parameters:
- W, 8, keystream bits per clock; legal values 1, 2, 4, 8, 16, 32, 64, each of which divides 1152. Any other value is an elaboration error.

Ports:
- clk_i  in  1  system clock; single clock domain.
- n_rst_i  in  1  reset; synchronous and active-low.
- start_i  in  1  load key/IV and begin warm-up.
- key_i  in  80  key; key_i[0] = K1.
- iv_i  in  80  IV; iv_i[0] = IV1.
- busy_o  out  1  high during WARMUP.
- ks_vld_o  out  1  keystream word valid; high in RUN.
- ks_rdy_i  in  1  consumer accepts word.
- ks_dat_o  out  W  keystream word; ks_dat_o[0] = earliest bit z.
- pt_i  in  W  plaintext word; present only with TRIVIUM_DAT_XOR_EN.

## Operation
- State s1..s288 is stored as three registers: A (s1..s93), B (s94..s177), C (s178..s288).
- Load: A = {K1..K80, 13 zeros}; B = {IV1..IV80, 4 zeros}; C = {108 zeros, 1, 1, 1}.
- Round: t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3. Then t1 ^= s91&s92 ^ s171; t2 ^= s175&s176 ^ s264; t3 ^= s286&s287 ^ s69. Shift A in t3, B in t1, C in t2.
- One clock applies W chained rounds. Bit i of the word is the z of round i, counting from 0.
- FSM states:
  - IDLE: on start_i, load the state, set cnt = 1152/W, go to WARMUP.
  - WARMUP: advance W rounds per clock and decrement cnt. When cnt reaches 1, go to RUN on the same edge. start_i is ignored.
  - RUN: the state advances only on ks_vld_o & ks_rdy_i. start_i reloads the state and goes to WARMUP, and has priority over a handshake in the same cycle.
- cnt width is $clog2(1152/W + 1). It never wraps.
- Reset (sampled, active-low): state registers and cnt clear to 0, FSM goes to IDLE, busy_o = 0, ks_vld_o = 0. This is also the behaviour when reset is asserted mid-warm-up or mid-stream.
- ks_dat_o is combinational from the state only. Its value is don't-care outside RUN but must be driven (no X).

## Timing
- start_i high at edge E0 loads the state. busy_o is high from E0 to E(1152/W).
- ks_vld_o is high starting at edge E(1152/W). Examples: W=8 gives 144 warm-up cycles, W=64 gives 18.
- The first word is the z of rounds 1153..1152+W.
- A handshake at edge En means the next word is presented after En. The word holds stable while ks_rdy_i is low.
- With ks_rdy_i held high, throughput is W bits per clock.
- No combinational path from ks_rdy_i or start_i to any output.

## Configuration
- TRIVIUM_DAT_XOR_EN defined:
  - pt_i port exists.
  - ks_dat_o = z ^ pt_i (combinational); pt_i is qualified by the handshake.
- TRIVIUM_DAT_XOR_EN undefined:
  - pt_i is absent.
  - ks_dat_o = z.

## Structure
- Shared package trivium_pkg:
  - Register lengths 93/84/111.
  - Tap indices 66, 69, 91, 92, 93, 162, 171, 175, 176, 177, 243, 264, 286, 287, 288.
  - WARMUP_ROUNDS = 1152.
  - FSM state enum {IDLE, WARMUP, RUN}.
- Sub-module trivium_round: combinational single round (288-bit state in, 288-bit state out, z out), chained W times by a generate loop in trivium_core_wide.

## Test plan
- Reset, then start_i with key=0, iv=0, W=8: busy_o high for exactly 144 cycles. The first 64 words match a bit-serial golden model. For W=8 the 1st word has ks_dat_o[0] = z1153.
- Same key/IV run with W=1, W=8 and W=64: the concatenated keystream over the first 4096 bits is identical across all three builds.
- ks_rdy_i toggles randomly 50% in RUN: ks_dat_o is stable while ks_rdy_i is low, and no word is skipped or duplicated against the golden model.
- start_i pulsed mid-WARMUP at cycle 50 is ignored, and ks_vld_o still rises at cycle 144. start_i pulsed in RUN together with ks_rdy_i reloads: ks_vld_o drops next cycle and returns 144 cycles later with the new key's stream.
- n_rst_i low for 1 cycle mid-warm-up and again mid-stream: the next edge shows IDLE, busy_o = 0, ks_vld_o = 0. The following start_i reproduces the stream from the beginning.
- TRIVIUM_DAT_XOR_EN build with pt_i = all-ones: ks_dat_o equals the bitwise inverse of the keystream from the non-XOR build.

Source files
------------

// File: rtl/trivium_pkg.sv
// trivium_pkg: shared Trivium lengths, tap positions (1-based, s1..s288), warm-up length and FSM states.
package trivium_pkg;
  localparam int LEN_A = 93;
  localparam int LEN_B = 84;
  localparam int LEN_C = 111;
  localparam int T66 = 66, T69 = 69, T91 = 91, T92 = 92, T93 = 93;
  localparam int T162 = 162, T171 = 171, T175 = 175, T176 = 176, T177 = 177;
  localparam int T243 = 243, T264 = 264, T286 = 286, T287 = 287, T288 = 288;
  localparam int WARMUP_ROUNDS = 1152;
  typedef enum logic [1:0] {IDLE, WARMUP, RUN} fsm_t;
  function automatic bit legal_w(int w);
    return w inside {1, 2, 4, 8, 16, 32, 64};
  endfunction
endpackage

// File: rtl/trivium_round.sv
// trivium_round: one combinational Trivium round; s[i-1] holds state bit s_i.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [287:0] s,
  output logic [287:0] ns,
  output logic         z
);
  logic t1, t2, t3;
  assign t1 = s[T66-1] ^ s[T93-1];
  assign t2 = s[T162-1] ^ s[T177-1];
  assign t3 = s[T243-1] ^ s[T288-1];
  assign z  = t1 ^ t2 ^ t3;
  // each register shifts towards higher indices and takes its feedback at its first bit
  assign ns = {s[286:177], t2 ^ (s[T175-1] & s[T176-1]) ^ s[T264-1],
               s[175:93],  t1 ^ (s[T91-1] & s[T92-1]) ^ s[T171-1],
               s[91:0],    t3 ^ (s[T286-1] & s[T287-1]) ^ s[T69-1]};
endmodule

// File: rtl/trivium_core_wide.sv
// trivium_core_wide: W-bit-per-clock Trivium keystream core with key/IV load, warm-up and valid/ready output.
// Defining TRIVIUM_DAT_XOR_EN adds pt_i and XORs it into ks_dat_o.
module trivium_core_wide
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  input  logic         start_i,
  input  logic [79:0]  key_i,
  input  logic [79:0]  iv_i,
  output logic         busy_o,
  output logic         ks_vld_o,
  input  logic         ks_rdy_i,
`ifdef TRIVIUM_DAT_XOR_EN
  output logic [W-1:0] ks_dat_o,
  input  logic [W-1:0] pt_i
`else
  output logic [W-1:0] ks_dat_o
`endif
);
  localparam int CNT_INIT = WARMUP_ROUNDS / W;
  localparam int CW = $clog2(CNT_INIT + 1);
  if (!legal_w(W)) begin : g_bad_w
    $error("trivium_core_wide: W must be one of 1,2,4,8,16,32,64");
  end
  fsm_t st;
  logic [CW-1:0] cnt;
  logic [LEN_A-1:0] a;
  logic [LEN_B-1:0] b;
  logic [LEN_C-1:0] c;
  logic [287:0] ch [W+1];
  logic [W-1:0] z;
  logic adv;
  assign ch[0] = {c, b, a};
  for (genvar g = 0; g < W; g++) begin : g_rnd
    trivium_round u_rnd (.s(ch[g]), .ns(ch[g+1]), .z(z[g]));
  end
  assign busy_o   = st == WARMUP;
  assign ks_vld_o = st == RUN;
  assign adv      = busy_o || (ks_vld_o && ks_rdy_i);
`ifdef TRIVIUM_DAT_XOR_EN
  assign ks_dat_o = z ^ pt_i;
`else
  assign ks_dat_o = z;
`endif
  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      st  <= IDLE;
      cnt <= '0;
      a   <= '0;
      b   <= '0;
      c   <= '0;
    end else if (start_i && st != WARMUP) begin
      st  <= WARMUP;
      cnt <= CW'(CNT_INIT);
      a   <= {13'b0, key_i};
      b   <= {4'b0, iv_i};
      c   <= {3'b111, 108'b0};
    end else if (adv) begin
      {c, b, a} <= ch[W];
      if (busy_o) begin
        cnt <= cnt - CW'(1);
        st  <= cnt == CW'(1) ? RUN : WARMUP;
      end
    end
  end
endmodule

// File: tb/tb_trivium_core_wide.sv
// tb_trivium_core_wide: directed bench against a bit-serial Trivium model feeding a word scoreboard.
module tb_trivium_core_wide;
  localparam int W  = 8;
  localparam int NW = 1152 / W;
  logic clk = 0, n_rst = 0, start = 0, rdy = 0;
  logic [79:0] key = '0, iv = '0;
  logic busy, vld;
  logic [W-1:0] dat;
`ifdef TRIVIUM_DAT_XOR_EN
  logic [W-1:0] pt = '1;
`endif
  int n_assert = 0, n_fail = 0;
  logic [W-1:0] sb [$];
  bit m [1:288];

  always #5 clk = ~clk;

  trivium_core_wide #(.W(W)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start), .key_i(key), .iv_i(iv),
    .busy_o(busy), .ks_vld_o(vld), .ks_rdy_i(rdy),
`ifdef TRIVIUM_DAT_XOR_EN
    .ks_dat_o(dat), .pt_i(pt)
`else
    .ks_dat_o(dat)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mstep(output bit z);
    bit t1, t2, t3;
    t1 = m[66] ^ m[93];
    t2 = m[162] ^ m[177];
    t3 = m[243] ^ m[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m[91] & m[92]) ^ m[171];
    t2 = t2 ^ (m[175] & m[176]) ^ m[264];
    t3 = t3 ^ (m[286] & m[287]) ^ m[69];
    for (int i = 288; i > 1; i--) m[i] = m[i-1];
    m[1] = t3;
    m[94] = t1;
    m[178] = t2;
  endtask

  task automatic mload(input logic [79:0] k, input logic [79:0] v);
    bit zb;
    logic [W-1:0] w;
    for (int i = 1; i <= 288; i++) m[i] = 0;
    for (int i = 0; i < 80; i++) begin
      m[i+1]  = k[i];
      m[i+94] = v[i];
    end
    m[286] = 1; m[287] = 1; m[288] = 1;
    for (int i = 0; i < 1152; i++) mstep(zb);
    sb.delete();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < W; i++) begin
        mstep(zb);
        w[i] = zb;
      end
`ifdef TRIVIUM_DAT_XOR_EN
      sb.push_back(w ^ pt);
`else
      sb.push_back(w);
`endif
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [79:0] k, input logic [79:0] v);
    key = k;
    iv = v;
    start = 1;
    tick;
    start = 0;
    mload(k, v);
  endtask

  task automatic wait_warm(input int poke);
    int cyc = 0;
    while (busy && cyc < 1000) begin
      if (cyc == poke) begin
        key = ~key;
        start = 1;
      end else start = 0;
      cyc++;
      tick;
    end
    start = 0;
    check("busy_len", cyc, NW);
    check("vld_rise", vld, 1);
  endtask

  task automatic consume(input int n, input bit rnd);
    int got = 0, guard = 0;
    bit hold = 0;
    logic [W-1:0] held = '0, exp;
    while (got < n && guard < 20 * n + 100) begin
      guard++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) check("stable", dat, held);
      if (vld && rdy) begin
        exp = sb.pop_front();
        check("word", dat, exp);
        got++;
        hold = 0;
      end else begin
        hold = vld;
        held = dat;
      end
      tick;
    end
    rdy = 0;
    if (got < n) check("consume_timeout", got, n);
  endtask

  initial begin
    logic [79:0] k1, v1, k2, v2;
    k1 = 80'({$urandom(), $urandom(), $urandom()});
    v1 = 80'({$urandom(), $urandom(), $urandom()});
    k2 = 80'({$urandom(), $urandom(), $urandom()});
    v2 = 80'({$urandom(), $urandom(), $urandom()});
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_vld", vld, 0);
`ifdef TRIVIUM_DAT_XOR_EN
    check("rst_dat", dat, pt);
`else
    check("rst_dat", dat, 0);
`endif
    n_rst = 1;
    tick;
    check("idle_busy", busy, 0);
    start_run('0, '0);
    check("start_busy", busy, 1);
    wait_warm(-1);
    consume(64, 0);
    consume(100, 1);
    key = k1;
    iv = v1;
    start = 1;
    rdy = 1;
    tick;
    start = 0;
    rdy = 0;
    check("reload_vld", vld, 0);
    check("reload_busy", busy, 1);
    mload(k1, v1);
    wait_warm(50);
    key = k1;
    consume(32, 1);
    start_run(k2, v2);
    repeat (20) tick;
    n_rst = 0;
    tick;
    n_rst = 1;
    check("rst_warm_busy", busy, 0);
    check("rst_warm_vld", vld, 0);
    start_run(k2, v2);
    wait_warm(-1);
    consume(16, 0);
    n_rst = 0;
    tick;
    n_rst = 1;
    check("rst_run_busy", busy, 0);
    check("rst_run_vld", vld, 0);
    start_run(k2, v2);
    wait_warm(-1);
    consume(16, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
